// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [6:0]  SEG_OFF    = 7'h7F;
    localparam logic [3:0]  DIG_OFF    = 4'hF;

    // Everything captured by a load and later shown on the display.
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        blank_lz;
    } disp_t;

    // Active-low one-cold digit select for the given index.
    function automatic logic [3:0] dig_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Host-side bus of the scan controller: shadow load port, enable and status.
interface seg7_scan_ctrl_if;

    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        blank_lz;
    logic        enable;
    logic        pending;
    logic        frame_start;

    modport master (
        output value, dp, load, blank_lz, enable,
        input  pending, frame_start
    );

    modport slave (
        input  value, dp, load, blank_lz, enable,
        output pending, frame_start
    );

endinterface

// File: rtl/seg7_scan_ctrl_hex7segment.sv
// Hex nibble to active-low 7-segment pattern, seg = {g,f,e,d,c,b,a}.
module hex7segment (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Pure lookup of the glyph for each hex digit.
    always_comb begin
        seg = 7'h7F;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with a frame-synchronous shadow
// register, anti-ghost blanking at the start of each slot and optional
// leading-zero suppression. All display outputs are registered.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned DIGIT_TICKS = 100000,
    parameter int unsigned BLANK_TICKS = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    seg7_scan_ctrl_if.slave  host,
    output logic [6:0]       seg,
    output logic             dp_n,
    output logic [3:0]       dig_n
);

    localparam int unsigned      CNT_W     = $clog2(DIGIT_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK_TICKS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    disp_t            shadow_q, shadow_d;
    disp_t            disp_q, disp_d;
    logic             pending_q, pending_d;
    logic             frame_start_q, frame_start_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_n_q, dp_n_d;
    logic [3:0]       dig_n_q, dig_n_d;

    logic             wrap;
    logic             boundary;
    logic             lz_blank;
    logic             nz_above;
    logic [6:0]       hex_seg;

    hex7segment u_hex (
        .hex (disp_q.value[{idx_q, 2'b00} +: 4]),
        .seg (hex_seg)
    );

    // Slot tick counter and digit index; a frame ends when digit 3 wraps.
    always_comb begin
        wrap     = (cnt_q == CNT_MAX);
        boundary = wrap && (idx_q == 2'd3);
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        idx_d    = wrap ? idx_q + 2'd1 : idx_q;
    end

    // Shadow capture and frame-synchronous transfer into the display register.
    // The transfer uses the pre-edge shadow, so a load on the boundary cycle
    // lands in the shadow and stays pending for the following frame.
    always_comb begin
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        if (boundary && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end
        if (host.load) begin
            shadow_d  = '{value: host.value, dp: host.dp, blank_lz: host.blank_lz};
            pending_d = 1'b1;
        end
    end

    // Segment, decimal point and digit drive for the current slot.
    always_comb begin
        nz_above = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (i >= 32'(idx_q) && disp_q.value[4*i +: 4] != 4'h0) begin
                nz_above = 1'b1;
            end
        end
        lz_blank      = disp_q.blank_lz && (idx_q != 2'd0) && !nz_above;
        frame_start_d = boundary;
        seg_d         = SEG_OFF;
        dp_n_d        = 1'b1;
        dig_n_d       = DIG_OFF;
        if (host.enable && cnt_q >= BLANK_CNT) begin
            dig_n_d = dig_sel(idx_q);
            seg_d   = lz_blank ? SEG_OFF : hex_seg;
            dp_n_d  = ~disp_q.dp[idx_q];
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_q      <= '0;
            disp_q        <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            seg_q         <= SEG_OFF;
            dp_n_q        <= 1'b1;
            dig_n_q       <= DIG_OFF;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            disp_q        <= disp_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
            seg_q         <= seg_d;
            dp_n_q        <= dp_n_d;
            dig_n_q       <= dig_n_d;
        end
    end

    assign seg              = seg_q;
    assign dp_n             = dp_n_q;
    assign dig_n            = dig_n_q;
    assign host.pending     = pending_q;
    assign host.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGIT_TICKS=8, BLANK_TICKS=2.
// Position n counts negedges after a frame boundary edge (n=32 is the next
// frame_start); slot s=(n-1)/8 is active when (n-1)%8 >= BLANK_TICKS.
module tb_seg7_scan_ctrl;

    localparam int DT = 8;
    localparam int BT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] seg;
    logic       dp_n;
    logic [3:0] dig_n;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    seg7_scan_ctrl_if host_if ();

    seg7_scan_ctrl #(
        .DIGIT_TICKS (DT),
        .BLANK_TICKS (BT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (host_if),
        .seg   (seg),
        .dp_n  (dp_n),
        .dig_n (dig_n)
    );

    always #5 clk = ~clk;

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic b);
        host_if.value    = v;
        host_if.dp       = d;
        host_if.blank_lz = b;
        host_if.load     = 1'b1;
        @(negedge clk);
        host_if.load     = 1'b0;
    endtask

    // One full frame starting right after a boundary; segs = {d3,d2,d1,d0}.
    task automatic check_frame(input string name, input logic [27:0] segs, input logic [3:0] dps);
        int slot, pos;
        logic [3:0] exp_dig;
        logic [6:0] exp_seg;
        logic       exp_dpn;
        logic       exp_fs;
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            slot = (n - 1) / DT;
            pos  = (n - 1) % DT;
            if (pos >= BT) begin
                exp_dig = ~(4'b0001 << slot);
                exp_seg = segs[7*slot +: 7];
                exp_dpn = ~dps[slot];
            end else begin
                exp_dig = 4'hF;
                exp_seg = 7'h7F;
                exp_dpn = 1'b1;
            end
            exp_fs = (n == 32);
            assert_cnt += 4;
            if (dig_n !== exp_dig) begin
                fail_cnt++;
                $display("FAIL %s dig_n n=%0d got %b want %b", name, n, dig_n, exp_dig);
            end
            if (seg !== exp_seg) begin
                fail_cnt++;
                $display("FAIL %s seg n=%0d got %h want %h", name, n, seg, exp_seg);
            end
            if (dp_n !== exp_dpn) begin
                fail_cnt++;
                $display("FAIL %s dp_n n=%0d got %b want %b", name, n, dp_n, exp_dpn);
            end
            if (host_if.frame_start !== exp_fs) begin
                fail_cnt++;
                $display("FAIL %s frame_start n=%0d got %b want %b", name, n, host_if.frame_start, exp_fs);
            end
        end
    endtask

    task automatic test_reset();
        host_if.value    = '0;
        host_if.dp       = '0;
        host_if.load     = 1'b0;
        host_if.blank_lz = 1'b0;
        host_if.enable   = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        assert_cnt += 5;
        if (seg !== 7'h7F) begin fail_cnt++; $display("FAIL reset seg got %h want 7f", seg); end
        if (dp_n !== 1'b1) begin fail_cnt++; $display("FAIL reset dp_n got %b want 1", dp_n); end
        if (dig_n !== 4'hF) begin fail_cnt++; $display("FAIL reset dig_n got %b want 1111", dig_n); end
        if (host_if.pending !== 1'b0) begin fail_cnt++; $display("FAIL reset pending got %b want 0", host_if.pending); end
        if (host_if.frame_start !== 1'b0) begin fail_cnt++; $display("FAIL reset frame_start got %b want 0", host_if.frame_start); end
        rst_n = 1'b1;
        check_frame("reset_scan0", {4{7'h40}}, 4'b0000);
        check_frame("reset_scan1", {4{7'h40}}, 4'b0000);
    endtask

    task automatic test_load();
        repeat (5) @(negedge clk);
        do_load(16'h1A3F, 4'b0100, 1'b0);
        for (int n = 6; n <= 32; n++) begin
            if (n > 6) @(negedge clk);
            assert_cnt += 2;
            if (host_if.pending !== (n < 32)) begin
                fail_cnt++;
                $display("FAIL load pending n=%0d got %b want %b", n, host_if.pending, (n < 32));
            end
            if (host_if.frame_start !== (n == 32)) begin
                fail_cnt++;
                $display("FAIL load frame_start n=%0d got %b want %b", n, host_if.frame_start, (n == 32));
            end
        end
        check_frame("load_1a3f", {7'h79, 7'h08, 7'h30, 7'h0E}, 4'b0100);
    endtask

    task automatic test_back_to_back();
        repeat (3) @(negedge clk);
        do_load(16'h1111, 4'b0000, 1'b0);
        repeat (5) @(negedge clk);
        do_load(16'h2222, 4'b0000, 1'b0);
        repeat (22) @(negedge clk);
        assert_cnt += 2;
        if (host_if.frame_start !== 1'b1) begin fail_cnt++; $display("FAIL b2b frame_start got %b want 1", host_if.frame_start); end
        if (host_if.pending !== 1'b0) begin fail_cnt++; $display("FAIL b2b pending got %b want 0", host_if.pending); end
        check_frame("last_wins", {4{7'h24}}, 4'b0000);
        // Load 3333 mid-frame, then 4444 exactly on the boundary cycle.
        repeat (2) @(negedge clk);
        do_load(16'h3333, 4'b0000, 1'b0);
        repeat (28) @(negedge clk);
        do_load(16'h4444, 4'b0000, 1'b0);
        assert_cnt += 2;
        if (host_if.frame_start !== 1'b1) begin fail_cnt++; $display("FAIL bnd_load frame_start got %b want 1", host_if.frame_start); end
        if (host_if.pending !== 1'b1) begin fail_cnt++; $display("FAIL bnd_load pending got %b want 1", host_if.pending); end
        check_frame("bnd_old_shadow", {4{7'h30}}, 4'b0000);
        assert_cnt++;
        if (host_if.pending !== 1'b0) begin fail_cnt++; $display("FAIL bnd_load pending_clear got %b want 0", host_if.pending); end
        check_frame("bnd_new_shadow", {4{7'h19}}, 4'b0000);
    endtask

    task automatic test_blank_lz();
        repeat (4) @(negedge clk);
        do_load(16'h0050, 4'b0000, 1'b1);
        repeat (27) @(negedge clk);
        check_frame("lz_0050", {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b0000);
        do_load(16'h0000, 4'b1000, 1'b1);
        repeat (31) @(negedge clk);
        check_frame("lz_0000", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1000);
    endtask

    task automatic test_enable();
        repeat (5) @(negedge clk);
        host_if.enable = 1'b0;
        for (int n = 6; n <= 25; n++) begin
            @(negedge clk);
            assert_cnt += 4;
            if (dig_n !== 4'hF) begin fail_cnt++; $display("FAIL enable dig_n n=%0d got %b want 1111", n, dig_n); end
            if (seg !== 7'h7F) begin fail_cnt++; $display("FAIL enable seg n=%0d got %h want 7f", n, seg); end
            if (dp_n !== 1'b1) begin fail_cnt++; $display("FAIL enable dp_n n=%0d got %b want 1", n, dp_n); end
            if (host_if.frame_start !== 1'b0) begin fail_cnt++; $display("FAIL enable frame_start n=%0d got %b want 0", n, host_if.frame_start); end
        end
        host_if.enable = 1'b1;
        for (int n = 26; n <= 32; n++) begin
            @(negedge clk);
            assert_cnt++;
            if (host_if.frame_start !== (n == 32)) begin
                fail_cnt++;
                $display("FAIL enable spacing n=%0d got %b want %b", n, host_if.frame_start, (n == 32));
            end
        end
        check_frame("enable_resume", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1000);
    endtask

    task automatic test_reset_pending();
        repeat (3) @(negedge clk);
        do_load(16'h5555, 4'hF, 1'b0);
        assert_cnt++;
        if (host_if.pending !== 1'b1) begin fail_cnt++; $display("FAIL rstp pending_set got %b want 1", host_if.pending); end
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        assert_cnt += 4;
        if (host_if.pending !== 1'b0) begin fail_cnt++; $display("FAIL rstp pending got %b want 0", host_if.pending); end
        if (dig_n !== 4'hF) begin fail_cnt++; $display("FAIL rstp dig_n got %b want 1111", dig_n); end
        if (seg !== 7'h7F) begin fail_cnt++; $display("FAIL rstp seg got %h want 7f", seg); end
        if (dp_n !== 1'b1) begin fail_cnt++; $display("FAIL rstp dp_n got %b want 1", dp_n); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_frame("rstp_scan0", {4{7'h40}}, 4'b0000);
        assert_cnt++;
        if (host_if.pending !== 1'b0) begin fail_cnt++; $display("FAIL rstp pending_after got %b want 0", host_if.pending); end
        check_frame("rstp_scan1", {4{7'h40}}, 4'b0000);
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_blank_lz();
        test_enable();
        test_reset_pending();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
